// File: rtl/shift_ctrl_if.sv
// shift_ctrl_if
// Bundles the word handshake and the serial/status outputs of shift_ctrl.
//   in_data   : parallel word to transmit (DATA_WIDTH bits)
//   in_valid  : in_data valid
//   in_ready  : sequencer can accept a word this cycle
//   ser_out   : serial data, MSB first
//   ser_frame : high while a frame bit is on ser_out
//   busy      : high while shifting or in the inter-frame gap
//   done      : one-cycle pulse after a frame's last bit period
// Modports: master = word producer / observer, slave = shift_ctrl.
interface shift_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  ser_out;
  logic                  ser_frame;
  logic                  busy;
  logic                  done;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_frame, busy, done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_frame, busy, done
  );
endinterface

// File: rtl/shift_ctrl.sv
// shift_ctrl
// Parallel-to-serial frame sequencer. Accepts a word over valid/ready,
// shifts it out MSB first holding each bit for CLK_DIV cycles, then
// enforces GAP_CYCLES idle cycles before the next accept.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : shift_ctrl_if.slave (in_data/in_valid/in_ready handshake,
//         ser_out/ser_frame/busy/done registered outputs)
// Optional feature macro: SHIFT_CTRL_PARITY_EN -- appends one even-parity
// bit period after the LSB.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | in_ready=1, waiting for in_valid
// S_SHIFT | frame bits on ser_out, CLK_DIV cycles per bit
// S_GAP   | enforced idle after a frame (first cycle carries done)
module shift_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  shift_ctrl_if.slave bus
);

`ifdef SHIFT_CTRL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int FRAME_BITS = DATA_WIDTH + PAR_BITS;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  ser_out_q, ser_out_d;
  logic                  ser_frame_q, ser_frame_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [FRAME_BITS-1:0] load_word;

  // Parity is taken from the word as presented at the handshake edge and
  // rides in the shift register as the final bit.
`ifdef SHIFT_CTRL_PARITY_EN
  assign load_word = {bus.in_data, ^bus.in_data};
`else
  assign load_word = bus.in_data;
`endif

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    div_d       = div_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    ser_out_d   = 1'b0;
    ser_frame_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.in_valid) begin
          state_d     = S_SHIFT;
          sh_d        = load_word;
          div_d       = '0;
          bit_d       = '0;
          ser_out_d   = load_word[FRAME_BITS-1];
          ser_frame_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_SHIFT: begin
        ser_frame_d = 1'b1;
        ser_out_d   = sh_q[FRAME_BITS-1];
        busy_d      = 1'b1;
        // With CLK_DIV=1 div_q is stuck at 0 == DIV_LAST: shift every cycle.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sh_d  = {sh_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            bit_d       = '0;
            ser_frame_d = 1'b0;
            ser_out_d   = 1'b0;
            done_d      = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d     = bit_q + 1'b1;
            // Registered output must already show the next bit.
            ser_out_d = sh_q[FRAME_BITS-2];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = '0;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_frame_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_frame = ser_frame_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_shift_ctrl.sv
`timescale 1ns/1ps
module tb_shift_ctrl;

`ifdef SHIFT_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  localparam int DW_A  = 8;
  localparam int CD_A  = 2;
  localparam int GAP_A = 2;
  localparam int FL_A  = (DW_A + PAR) * CD_A;
  localparam int DW_B  = 4;
  localparam int CD_B  = 1;
  localparam int GAP_B = 0;
  localparam int FL_B  = (DW_B + PAR) * CD_B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic exp_a[$];
  logic exp_b[$];
  int   acc_a[$];
  logic e_a, e_b;

  shift_ctrl_if #(.DATA_WIDTH(DW_A)) ifa();
  shift_ctrl_if #(.DATA_WIDTH(DW_B)) ifb();

  shift_ctrl #(.DATA_WIDTH(DW_A), .CLK_DIV(CD_A), .GAP_CYCLES(GAP_A)) u_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  shift_ctrl #(.DATA_WIDTH(DW_B), .CLK_DIV(CD_B), .GAP_CYCLES(GAP_B)) u_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // accept log for spacing / single-accept checks on DUT A
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && ifa.in_valid === 1'b1 && ifa.in_ready === 1'b1) acc_a.push_back(cyc);
  end

  // scoreboards: pop one expected bit per ser_frame cycle; ser_out must be 0 outside frames
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (ifa.ser_frame === 1'b1) begin
        if (exp_a.size() == 0) begin
          failures++;
          $display("FAIL sb_a_extra: ser_frame=1 with no expected bit at cycle %0d", cyc);
        end else begin
          e_a = exp_a.pop_front();
          if (ifa.ser_out !== e_a) begin
            failures++;
            $display("FAIL sb_a_bit: ser_out=%b expected %b at cycle %0d", ifa.ser_out, e_a, cyc);
          end
        end
      end else if (ifa.ser_out !== 1'b0) begin
        failures++;
        $display("FAIL sb_a_idle: ser_out=%b expected 0 outside frame at cycle %0d", ifa.ser_out, cyc);
      end
      checks++;
      if (ifb.ser_frame === 1'b1) begin
        if (exp_b.size() == 0) begin
          failures++;
          $display("FAIL sb_b_extra: ser_frame=1 with no expected bit at cycle %0d", cyc);
        end else begin
          e_b = exp_b.pop_front();
          if (ifb.ser_out !== e_b) begin
            failures++;
            $display("FAIL sb_b_bit: ser_out=%b expected %b at cycle %0d", ifb.ser_out, e_b, cyc);
          end
        end
      end else if (ifb.ser_out !== 1'b0) begin
        failures++;
        $display("FAIL sb_b_idle: ser_out=%b expected 0 outside frame at cycle %0d", ifb.ser_out, cyc);
      end
    end
  end

  function automatic void push_a(input logic [DW_A-1:0] w);
    for (int i = DW_A - 1; i >= 0; i--)
      for (int k = 0; k < CD_A; k++) exp_a.push_back(w[i]);
    if (PAR == 1)
      for (int k = 0; k < CD_A; k++) exp_a.push_back(^w);
  endfunction

  function automatic void push_b(input logic [DW_B-1:0] w);
    for (int i = DW_B - 1; i >= 0; i--)
      for (int k = 0; k < CD_B; k++) exp_b.push_back(w[i]);
    if (PAR == 1)
      for (int k = 0; k < CD_B; k++) exp_b.push_back(^w);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifa.ser_out, ifa.ser_frame, ifa.busy, ifa.done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_a_outputs: {ser_out,frame,busy,done}=%b expected 0000", {ifa.ser_out, ifa.ser_frame, ifa.busy, ifa.done});
    end
    checks++;
    if ({ifb.ser_out, ifb.ser_frame, ifb.busy, ifb.done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_b_outputs: {ser_out,frame,busy,done}=%b expected 0000", {ifb.ser_out, ifb.ser_frame, ifb.busy, ifb.done});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready a=%b b=%b expected 1 1", ifa.in_ready, ifb.in_ready);
    end
  endtask

  task automatic test_frame(input logic [7:0] w);
    int fh;
    fh = 0;
    @(posedge clk); #1;
    ifa.in_data = w; ifa.in_valid = 1'b1; push_a(w);
    @(negedge clk);
    checks++;
    if (ifa.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL frame_ready_pre: in_ready=%b expected 1", ifa.in_ready);
    end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0; ifa.in_data = ~w;
    for (int k = 1; k <= FL_A; k++) begin
      @(negedge clk);
      if (ifa.ser_frame === 1'b1) fh++;
      checks++;
      if ({ifa.busy, ifa.in_ready, ifa.done} !== 3'b100) begin
        failures++;
        $display("FAIL frame_ctl: {busy,ready,done}=%b expected 100 at T+%0d", {ifa.busy, ifa.in_ready, ifa.done}, k);
      end
    end
    checks++;
    if (fh != FL_A) begin
      failures++;
      $display("FAIL frame_len: ser_frame high %0d cycles expected %0d", fh, FL_A);
    end
    @(negedge clk);
    checks++;
    if ({ifa.ser_frame, ifa.ser_out, ifa.done, ifa.busy, ifa.in_ready} !== 5'b00110) begin
      failures++;
      $display("FAIL frame_done: {frame,ser_out,done,busy,ready}=%b expected 00110", {ifa.ser_frame, ifa.ser_out, ifa.done, ifa.busy, ifa.in_ready});
    end
    for (int k = 2; k <= GAP_A; k++) begin
      @(negedge clk);
      checks++;
      if ({ifa.done, ifa.busy, ifa.in_ready} !== 3'b010) begin
        failures++;
        $display("FAIL frame_gap: {done,busy,ready}=%b expected 010", {ifa.done, ifa.busy, ifa.in_ready});
      end
    end
    @(negedge clk);
    checks++;
    if ({ifa.busy, ifa.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL frame_ready_post: {busy,ready}=%b expected 01", {ifa.busy, ifa.in_ready});
    end
    checks++;
    if (exp_a.size() != 0) begin
      failures++;
      $display("FAIL frame_sb_empty: %0d expected bits left, expected 0", exp_a.size());
    end
  endtask

  task automatic test_back_to_back();
    int t;
    acc_a.delete();
    @(posedge clk); #1;
    ifa.in_data = 8'hFF; ifa.in_valid = 1'b1; push_a(8'hFF);
    t = 0;
    while (acc_a.size() < 1 && t < 50) begin @(posedge clk); #1; t++; end
    ifa.in_data = 8'h00; push_a(8'h00);
    t = 0;
    while (acc_a.size() < 2 && t < 100) begin @(posedge clk); #1; t++; end
    ifa.in_valid = 1'b0;
    checks++;
    if (acc_a.size() != 2) begin
      failures++;
      $display("FAIL b2b_accepts: %0d accepts expected 2", acc_a.size());
    end else begin
      checks++;
      if (acc_a[1] - acc_a[0] != FL_A + GAP_A + 1) begin
        failures++;
        $display("FAIL b2b_spacing: %0d cycles expected %0d", acc_a[1] - acc_a[0], FL_A + GAP_A + 1);
      end
    end
    repeat (FL_A + GAP_A + 2) @(negedge clk);
    checks++;
    if (exp_a.size() != 0 || ifa.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: bits left=%0d in_ready=%b expected 0 and 1", exp_a.size(), ifa.in_ready);
    end
  endtask

  task automatic test_valid_during_shift();
    acc_a.delete();
    @(posedge clk); #1;
    ifa.in_data = 8'hA5; ifa.in_valid = 1'b1; push_a(8'hA5);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    ifa.in_data = 8'h3C; ifa.in_valid = 1'b1;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    repeat (FL_A + GAP_A + 20) @(negedge clk);
    checks++;
    if (acc_a.size() != 1) begin
      failures++;
      $display("FAIL busy_valid_accepts: %0d accepts expected 1", acc_a.size());
    end
    checks++;
    if (exp_a.size() != 0 || ifa.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_valid_end: bits left=%0d in_ready=%b expected 0 and 1", exp_a.size(), ifa.in_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dn;
    dn = 0;
    @(posedge clk); #1;
    ifa.in_data = 8'hA5; ifa.in_valid = 1'b1; push_a(8'hA5);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete();
    @(negedge clk);
    checks++;
    if ({ifa.ser_frame, ifa.ser_out, ifa.busy, ifa.done, ifa.in_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL midrst_outputs: {frame,ser_out,busy,done,ready}=%b expected 00001", {ifa.ser_frame, ifa.ser_out, ifa.busy, ifa.done, ifa.in_ready});
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL midrst_done: %0d done pulses expected 0", dn);
    end
  endtask

  task automatic test_clk_div1();
    int fh;
    fh = 0;
    @(posedge clk); #1;
    ifb.in_data = 4'b1001; ifb.in_valid = 1'b1; push_b(4'b1001);
    @(negedge clk);
    checks++;
    if (ifb.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL div1_ready_pre: in_ready=%b expected 1", ifb.in_ready);
    end
    @(posedge clk); #1;
    ifb.in_valid = 1'b0; ifb.in_data = 4'b0110;
    for (int k = 1; k <= FL_B; k++) begin
      @(negedge clk);
      if (ifb.ser_frame === 1'b1) fh++;
    end
    checks++;
    if (fh != FL_B) begin
      failures++;
      $display("FAIL div1_len: ser_frame high %0d cycles expected %0d", fh, FL_B);
    end
    @(negedge clk);
    checks++;
    if ({ifb.done, ifb.in_ready, ifb.ser_frame, ifb.ser_out, ifb.busy} !== 5'b11000) begin
      failures++;
      $display("FAIL div1_done: {done,ready,frame,ser_out,busy}=%b expected 11000", {ifb.done, ifb.in_ready, ifb.ser_frame, ifb.ser_out, ifb.busy});
    end
    checks++;
    if (exp_b.size() != 0) begin
      failures++;
      $display("FAIL div1_sb_empty: %0d expected bits left, expected 0", exp_b.size());
    end
  endtask

  initial begin
    ifa.in_data = '0; ifa.in_valid = 1'b0;
    ifb.in_data = '0; ifb.in_valid = 1'b0;
    test_reset();
    test_frame(8'hA5);
    test_frame(8'hA4);
    test_back_to_back();
    test_valid_during_shift();
    test_reset_mid_frame();
    test_clk_div1();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
